// File: rtl/spi_pkg.sv
// Shared definitions for the SPI byte link.
//   spi_tx_state_t : transmitter FSM state
//   SPI_BYTE_BITS  : bits per SPI byte
//   spi_max4       : largest of four ints, used to size phase counters
package spi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        LOW,
        HIGH,
        WAIT,
        HOLD,
        GAP
    } spi_tx_state_t;

    localparam int SPI_BYTE_BITS = 8;

    function automatic int spi_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/spi_master_tx.sv
// SPI mode-0 master transmitter. Accepts bytes over valid/ready, frames
// them under chip-select, shifts each byte MSB first on MOSI; the receiver
// samples MOSI on SCLK rising edges.
//
// Parameters
//   CLK_DIV  : SCLK half-period in clk cycles (>= 2)
//   CS_SETUP : cycles CS low before the first SCLK low phase (>= 1)
//   CS_HOLD  : cycles CS stays low after the last SCLK falling edge (>= 1)
//   CS_IDLE  : minimum cycles CS high between frames (>= 1)
// Ports
//   clk_in         : system clock, rising edge
//   rst_in         : synchronous active-high reset
//   byte_valid_in  : source has a byte
//   byte_last_in   : close the frame after this byte
//   byte_data_in   : byte to send
//   byte_ready_out : a byte is taken on this edge when valid is high
//   busy_out       : FSM is not idle
//   spi_sclk_out   : SPI clock, idles low (registered)
//   spi_mosi_out   : SPI data (registered)
//   spi_cs_n_out   : chip select, active-low (registered)
module spi_master_tx
    import spi_pkg::*;
#(
    parameter int CLK_DIV  = 4,
    parameter int CS_SETUP = 2,
    parameter int CS_HOLD  = 2,
    parameter int CS_IDLE  = 2
) (
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       byte_valid_in,
    input  logic       byte_last_in,
    input  logic [7:0] byte_data_in,
    output logic       byte_ready_out,
    output logic       busy_out,
    output logic       spi_sclk_out,
    output logic       spi_mosi_out,
    output logic       spi_cs_n_out
);

    localparam int DIV_W = $clog2(spi_max4(CLK_DIV, CS_SETUP, CS_HOLD, CS_IDLE));

    // Reload values: each state lasts (load + 1) cycles, counting down to zero.
    localparam logic [DIV_W-1:0] LD_SETUP = DIV_W'(CS_SETUP - 1);
    localparam logic [DIV_W-1:0] LD_PHASE = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] LD_HOLD  = DIV_W'(CS_HOLD - 1);
    localparam logic [DIV_W-1:0] LD_GAP   = DIV_W'(CS_IDLE - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [2:0]       BIT_TOP  = 3'(SPI_BYTE_BITS - 1);

    spi_tx_state_t            state_q, state_d;
    logic [DIV_W-1:0]         div_q, div_d;
    logic [2:0]               bit_q, bit_d;
    logic [SPI_BYTE_BITS-1:0] shift_q, shift_d;
    logic                     last_q, last_d;
    logic                     load;
    logic                     accept;
    logic                     phase_end;
    logic                     cs_n_d, sclk_d, mosi_d;

    assign phase_end = (div_q == '0);
    assign accept    = byte_valid_in & byte_ready_out;
    assign busy_out  = (state_q != IDLE);

    // Ready in the final HIGH cycle of bit 0 lets the next byte start
    // its LOW phase immediately, keeping bit spacing uniform.
    assign byte_ready_out = ~rst_in & ((state_q == IDLE) || (state_q == WAIT) ||
                            ((state_q == HIGH) && phase_end && (bit_q == 3'd0) && ~last_q));

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        load    = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SETUP;
                    div_d   = LD_SETUP;
                    load    = 1'b1;
                end
            end
            SETUP: begin
                if (phase_end) begin
                    state_d = LOW;
                    div_d   = LD_PHASE;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_d = HIGH;
                    div_d   = LD_PHASE;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    bit_d = bit_q - 3'd1;
                    if (bit_q != 3'd0) begin
                        state_d = LOW;
                        div_d   = LD_PHASE;
                        shift_d = {shift_q[SPI_BYTE_BITS-2:0], 1'b0};
                    end else if (last_q) begin
                        state_d = HOLD;
                        div_d   = LD_HOLD;
                    end else if (accept) begin
                        state_d = LOW;
                        div_d   = LD_PHASE;
                        load    = 1'b1;
                    end else begin
                        state_d = WAIT;
                        div_d   = '0;
                    end
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            WAIT: begin
                if (accept) begin
                    state_d = LOW;
                    div_d   = LD_PHASE;
                    load    = 1'b1;
                end
            end
            HOLD: begin
                if (phase_end) begin
                    state_d = GAP;
                    div_d   = LD_GAP;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            GAP: begin
                if (phase_end) begin
                    state_d = IDLE;
                    div_d   = '0;
                end else begin
                    div_d = div_q - DIV_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = '0;
            end
        endcase
        if (load) begin
            shift_d = byte_data_in;
            last_d  = byte_last_in;
            bit_d   = BIT_TOP;
        end
    end

    // Pins are decoded from the next state so they line up with the
    // state register and still come straight from flops.
    always_comb begin
        cs_n_d = (state_d == IDLE) || (state_d == GAP);
        sclk_d = (state_d == HIGH);
        mosi_d = 1'b0;
        if ((state_d == SETUP) || (state_d == LOW) || (state_d == HIGH) || (state_d == WAIT)) begin
            mosi_d = shift_d[SPI_BYTE_BITS-1];
        end
    end

    // ---- control and pin registers ----
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            div_q        <= '0;
            bit_q        <= '0;
            last_q       <= 1'b0;
            spi_cs_n_out <= 1'b1;
            spi_sclk_out <= 1'b0;
            spi_mosi_out <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            last_q       <= last_d;
            spi_cs_n_out <= cs_n_d;
            spi_sclk_out <= sclk_d;
            spi_mosi_out <= mosi_d;
        end
    end

    // ---- data shifter (not reset; only read while a byte is in flight) ----
    always_ff @(posedge clk_in) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_spi_master_tx.sv
// Bench for spi_master_tx: two instances (CLK_DIV 2 and 4) share one
// stimulus driver and one SPI receiver model selected by use_b.
module tb_spi_master_tx;

    localparam int DIV_A  = 2;
    localparam int DIV_B  = 4;
    localparam int T_SET  = 2;
    localparam int T_HOLD = 2;
    localparam int T_IDLE = 2;
    localparam int LIM    = 2000;

    logic       clk_in, rst_in, use_b;
    logic       vld, lst;
    logic [7:0] dat;
    logic       rdy_a, busy_a, sclk_a, mosi_a, cs_a;
    logic       rdy_b, busy_b, sclk_b, mosi_b, cs_b;
    logic       m_rdy, m_busy, m_sclk, m_mosi, m_cs_n;

    spi_master_tx #(.CLK_DIV(DIV_A), .CS_SETUP(T_SET), .CS_HOLD(T_HOLD), .CS_IDLE(T_IDLE)) dut_a (
        .clk_in(clk_in), .rst_in(rst_in),
        .byte_valid_in(vld & ~use_b), .byte_last_in(lst), .byte_data_in(dat),
        .byte_ready_out(rdy_a), .busy_out(busy_a),
        .spi_sclk_out(sclk_a), .spi_mosi_out(mosi_a), .spi_cs_n_out(cs_a)
    );

    spi_master_tx #(.CLK_DIV(DIV_B), .CS_SETUP(T_SET), .CS_HOLD(T_HOLD), .CS_IDLE(T_IDLE)) dut_b (
        .clk_in(clk_in), .rst_in(rst_in),
        .byte_valid_in(vld & use_b), .byte_last_in(lst), .byte_data_in(dat),
        .byte_ready_out(rdy_b), .busy_out(busy_b),
        .spi_sclk_out(sclk_b), .spi_mosi_out(mosi_b), .spi_cs_n_out(cs_b)
    );

    assign m_rdy  = use_b ? rdy_b  : rdy_a;
    assign m_busy = use_b ? busy_b : busy_a;
    assign m_sclk = use_b ? sclk_b : sclk_a;
    assign m_mosi = use_b ? mosi_b : mosi_a;
    assign m_cs_n = use_b ? cs_b   : cs_a;

    int         n_chk, n_err, cyc;
    int         q_fall[$], q_csr[$], q_sclk[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int         mosi_bad, stray;

    initial begin
        clk_in = 1'b0;
        forever #5 clk_in = ~clk_in;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk_in);
            cyc++;
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Receiver model: samples MOSI on SCLK rises inside the CS window,
    // assembles MSB-first bytes, and logs CS/SCLK event cycles.
    initial begin
        logic       p_cs, p_sclk, p_mosi;
        logic [7:0] sr;
        int         nbit, last_chg, div;
        p_cs = 1'b1; p_sclk = 1'b0; p_mosi = 1'b0;
        sr = '0; nbit = 0; last_chg = -1000;
        mosi_bad = 0; stray = 0;
        forever begin
            @(negedge clk_in);
            div = use_b ? DIV_B : DIV_A;
            if (!m_cs_n && p_cs) q_fall.push_back(cyc);
            if (m_cs_n && !p_cs) begin
                q_csr.push_back(cyc);
                nbit = 0;
            end
            if (m_mosi !== p_mosi) begin
                if (m_sclk) mosi_bad++;
                last_chg = cyc;
            end
            if (m_sclk && !p_sclk) begin
                if (!m_cs_n) begin
                    if (cyc - last_chg < div) mosi_bad++;
                    q_sclk.push_back(cyc);
                    sr = {sr[6:0], m_mosi};
                    nbit++;
                    if (nbit == 8) begin
                        rx_q.push_back(sr);
                        nbit = 0;
                    end
                end else begin
                    stray++;
                end
            end
            p_cs = m_cs_n; p_sclk = m_sclk; p_mosi = m_mosi;
        end
    end

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic clear_mon();
        q_fall.delete(); q_csr.delete(); q_sclk.delete();
        rx_q.delete(); exp_q.delete();
    endtask

    // Presents one byte and returns the cycle in which valid & ready were both high.
    task automatic push_byte(input logic [7:0] d, input logic l, output int acc);
        int n;
        n = 0;
        vld = 1'b1; dat = d; lst = l;
        #0;
        while (!m_rdy && n < LIM) begin
            step();
            n++;
        end
        check("accept_bound", int'(n < LIM), 1);
        acc = cyc;
        step();
        vld = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((m_busy || !m_cs_n) && n < LIM) begin
            step();
            n++;
        end
        check("idle_bound", int'(n < LIM), 1);
        repeat (3) step();
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check({tag, "_rx_byte"}, (i < rx_q.size()) ? int'(rx_q[i]) : -1, int'(exp_q[i]));
        end
    endtask

    task automatic check_spacing(input string tag, input int div);
        int bad;
        bad = 0;
        for (int i = 1; i < q_sclk.size(); i++) begin
            if (q_sclk[i] - q_sclk[i-1] != 2 * div) bad++;
        end
        check({tag, "_sclk_period"}, bad, 0);
    endtask

    initial begin
        int         acc, acc2, n, bad;
        logic [7:0] b1, b2;
        n_chk = 0; n_err = 0;
        rst_in = 1'b1; vld = 1'b0; lst = 1'b0; dat = '0; use_b = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_ready", int'(m_rdy), 0);
        check("rst_cs_n", int'(m_cs_n), 1);
        check("rst_sclk", int'(m_sclk), 0);
        check("rst_mosi", int'(m_mosi), 0);
        check("rst_busy", int'(m_busy), 0);
        rst_in = 1'b0;
        #1;
        check("ready_after_rst", int'(m_rdy), 1);
        step();

        // Single-byte frame 0xA5
        clear_mon();
        exp_q.push_back(8'hA5);
        push_byte(8'hA5, 1'b1, acc);
        n = 0;
        while (!m_rdy && n < 200) begin
            step();
            n++;
        end
        check("t1_ready_at", cyc - acc, T_SET + 16 * DIV_A + T_HOLD + 1 + T_IDLE);
        check("t1_cs_falls", q_fall.size(), 1);
        check("t1_cs_fall_at", (q_fall.size() > 0) ? q_fall[0] - acc : -1, 1);
        check("t1_cs_rise_at", (q_csr.size() > 0) ? q_csr[0] - acc : -1, T_SET + 16 * DIV_A + T_HOLD + 1);
        check("t1_sclk_pulses", q_sclk.size(), 8);
        check("t1_first_rise", (q_sclk.size() > 0) ? q_sclk[0] - acc : -1, 1 + T_SET + DIV_A);
        check_rx("t1");
        check_spacing("t1", DIV_A);
        repeat (4) step();

        // Burst 01 80 FF with valid held
        clear_mon();
        exp_q.push_back(8'h01); exp_q.push_back(8'h80); exp_q.push_back(8'hFF);
        push_byte(8'h01, 1'b0, acc);
        push_byte(8'h80, 1'b0, acc2);
        check("t2_gapless", acc2 - acc, 16 * DIV_A + T_SET);
        push_byte(8'hFF, 1'b1, acc2);
        wait_idle();
        check("t2_cs_windows", q_fall.size(), 1);
        check("t2_sclk_pulses", q_sclk.size(), 24);
        check("t2_cs_low", (q_csr.size() > 0 && q_fall.size() > 0) ? q_csr[0] - q_fall[0] : -1,
              T_SET + 48 * DIV_A + T_HOLD);
        check_rx("t2");
        check_spacing("t2", DIV_A);

        // Source stall of 20 cycles between bytes
        clear_mon();
        b1 = 8'($urandom); b2 = 8'($urandom);
        exp_q.push_back(b1); exp_q.push_back(b2);
        push_byte(b1, 1'b0, acc);
        n = 0;
        while (cyc < acc + 1 + T_SET + 16 * DIV_A && n < LIM) begin
            step();
            n++;
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            if (m_cs_n !== 1'b0 || m_sclk !== 1'b0 || m_rdy !== 1'b1 || m_mosi !== b1[0]) bad++;
            step();
        end
        check("t3_wait_hold", bad, 0);
        push_byte(b2, 1'b1, acc2);
        wait_idle();
        check("t3_cs_windows", q_fall.size(), 1);
        check("t3_sclk_pulses", q_sclk.size(), 16);
        check_rx("t3");

        // Reset during bit 4 of 0x3C
        clear_mon();
        push_byte(8'h3C, 1'b1, acc);
        n = 0;
        while (cyc < acc + 2 + T_SET + 6 * DIV_A && n < LIM) begin
            step();
            n++;
        end
        rst_in = 1'b1;
        #1;
        check("t4_ready_in_rst", int'(m_rdy), 0);
        step();
        rst_in = 1'b0;
        check("t4_cs_n", int'(m_cs_n), 1);
        check("t4_sclk", int'(m_sclk), 0);
        check("t4_mosi", int'(m_mosi), 0);
        check("t4_busy", int'(m_busy), 0);
        step();
        check("t4_ready", int'(m_rdy), 1);
        repeat (40) step();
        check("t4_sclk_pulses", q_sclk.size(), 3);
        check("t4_rx_none", rx_q.size(), 0);

        // Valid offered during HOLD/GAP is held off until IDLE
        clear_mon();
        b1 = 8'($urandom); b2 = 8'($urandom);
        exp_q.push_back(b1); exp_q.push_back(b2);
        push_byte(b1, 1'b1, acc);
        push_byte(b2, 1'b1, acc2);
        wait_idle();
        check("t5_accept_gap", acc2 - acc, T_SET + 16 * DIV_A + T_HOLD + 1 + T_IDLE);
        // GAP holds CS high CS_IDLE cycles; the IDLE cycle in which the next
        // byte is accepted adds one more.
        check("t5_cs_high", (q_fall.size() > 1 && q_csr.size() > 0) ? q_fall[1] - q_csr[0] : -1, T_IDLE + 1);
        check_rx("t5");

        // Loopback: 256 random bytes in one frame at CLK_DIV = 4
        use_b = 1'b1;
        repeat (3) step();
        clear_mon();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(8'($urandom));
            push_byte(exp_q[i], (i == 255), acc);
        end
        wait_idle();
        check("t6_cs_windows", q_fall.size(), 1);
        check("t6_sclk_pulses", q_sclk.size(), 2048);
        check_spacing("t6", DIV_B);
        check_rx("t6");

        check("mosi_stable", mosi_bad, 0);
        check("stray_sclk", stray, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
